dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RV32I core. It serves load/store requests issued by the MEM stage. It holds the data array, applies a configurable access latency, and stalls the pipeline until each access completes. It returns sign- or zero-extended load data on `readdata_m` for capture by the MEM/WB pipeline register.

## Interface
- `DATA_WIDTH`, 32: data path width; only 32 is supported.
- `DEPTH`, 1024: number of 32-bit words; must be a power of two.
- `LATENCY`, 2: cycles from request acceptance to response; must be ≥1.

Ports:
- `clk`  in  1  core clock; rising-edge.
- `rst`  in  1  reset: asynchronous, active-low.
- `req_valid_m`  in  1  MEM stage has a load or store.
- `req_write_m`  in  1  1 = store, 0 = load.
- `req_funct3_m`  in  3  RV32I size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr_m`  in  DATA_WIDTH  byte address (ALU result).
- `req_wdata_m`  in  DATA_WIDTH  store data; bytes taken LSB-first.
- `stall_m`  out  1  hold the pipeline; combinational.
- `resp_valid_m`  out  1  response cycle.
- `readdata_m`  out  DATA_WIDTH  extended load data; 0 when not a load response.
- `misaligned_m`  out  1  misaligned access flag, valid in the response cycle.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_valid_m`=1 latches address, funct3, write, wdata and alignment check.
  - Loads cnt with LATENCY-1.
  - Goes to RESP if LATENCY=1, else WAIT.
- WAIT:
  - cnt decrements each cycle; goes to RESP when cnt reaches 1.
  - If `req_valid_m` drops, it aborts to IDLE with no write and no response.
- RESP:
  - One cycle, then always IDLE.
  - A load reads the array on entry into RESP; the result is registered in `rdata_q`.
  - A store commits on the rising edge that ends RESP, through byte enables.
- Word index is `addr[log2(DEPTH)+1:2]`. Higher address bits are ignored, so accesses wrap modulo DEPTH*4 bytes.
- Load extraction uses `addr[1:0]`:
  - b/bu select the byte; h/hu select the half at `addr[1]`.
  - b/h sign-extend; bu/hu zero-extend; w passes the word.
- Store byte enables:
  - sb: `1<<addr[1:0]`.
  - sh: `0011` or `1100` by `addr[1]`.
  - sw: `1111`.
- Misaligned: h/hu/sh with `addr[0]`=1, or w/sw with `addr[1:0]`≠0.
  - `misaligned_m`=1 in RESP, `readdata_m`=0, no write.
- Unsupported funct3 (011, 110, 111): treated as misaligned.
- Array contents are not reset. Simulation initial contents are zero.

## Timing
- `stall_m` = (IDLE & `req_valid_m`) | WAIT. It is 0 in RESP, so the pipeline advances on the edge that ends RESP.
- A request presented at cycle 0 (IDLE) gets RESP at cycle LATENCY. The requester sees LATENCY stall cycles; total occupancy is LATENCY+1 cycles.
- `resp_valid_m`=1 only in RESP. `readdata_m` and `misaligned_m` are 0 outside RESP.
- Back-to-back requests: RESP always returns to IDLE, so a new request is accepted in the cycle after RESP. One idle-accept cycle separates accesses; no overlap.
- Store-then-load to the same word: the load is accepted after the store's commit edge and returns the new data.
- Requester holds all `req_*` stable while `stall_m`=1. Only `req_valid_m` deassertion (flush) is honoured mid-access.
- Reset (`rst`=0, any time):
  - State returns to IDLE immediately; cnt=0, `rdata_q`=0.
  - Outputs: `stall_m`=0 (once `req_valid_m` is sampled in IDLE), `resp_valid_m`=0, `readdata_m`=0, `misaligned_m`=0.
  - An in-flight store is dropped; the array is unchanged.
- Reset release is synchronous to `clk` through the state register. The first request can be accepted in the first cycle with `rst`=1.

## Test plan
- Word store/load, LATENCY=2:
  - sw addr 0x10, data 0xDEADBEEF gives `stall_m` high for 2 cycles and RESP at cycle 2 with `misaligned_m`=0.
  - lw 0x10 gives `readdata_m`=0xDEADBEEF at cycle 2, `resp_valid_m`=1.
- Sub-word loads on 0xDEADBEEF at 0x10:
  - lb 0x13 gives 0xFFFFFFDE; lbu 0x13 gives 0x000000DE.
  - lh 0x12 gives 0xFFFFDEAD; lhu 0x10 gives 0x0000BEEF.
- Sub-word stores: sb 0x11 data 0x55, then lw 0x10, gives 0xDEAD55EF. sh 0x12 data 0x1234, then lw 0x10, gives 0x123455EF.
- Misaligned and wrap:
  - lw 0x12 gives `misaligned_m`=1 and `readdata_m`=0.
  - sh 0x11 gives `misaligned_m`=1 and memory unchanged.
  - With DEPTH=1024, lw 0x1010 returns the word at 0x10.
- Abort/reset:
  - sw 0x20 0xAAAA5555 with `req_valid_m` dropped in WAIT gives no RESP; a later lw 0x20 returns the old value.
  - `rst` low during WAIT of sw 0x20 returns to IDLE immediately with all outputs 0, and lw 0x20 after release returns the unchanged word.
- LATENCY=1 back-to-back: lw, lw, sw, lw stream gives RESP every second cycle, `stall_m` pattern 1,0,1,0…, and the final load returns the stored data.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I MEM stage: a byte-lane RAM behind a
// fixed-latency handshake that stalls the pipeline until each access completes.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_m,
  input  logic                  req_write_m,
  input  logic [2:0]            req_funct3_m,
  input  logic [DATA_WIDTH-1:0] req_addr_m,
  input  logic [DATA_WIDTH-1:0] req_wdata_m,
  output logic                  stall_m,
  output logic                  resp_valid_m,
  output logic [DATA_WIDTH-1:0] readdata_m,
  output logic                  misaligned_m
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [AW+1:0]         addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [2:0]            funct3_reg;
  logic                  write_reg;
  logic                  mis_reg;
  logic                  accept;
  logic                  rd_en;
  logic                  wr_en;
  logic [AW-1:0]         rd_idx;
  logic [AW-1:0]         wr_idx;
  logic [LANES-1:0]      byte_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  unused_addr_bits;

  // Address bits above the array size are deliberately ignored (wrap-around).
  assign unused_addr_bits = ^req_addr_m[DATA_WIDTH-1:AW+2];

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      3'b010:         return (a != 2'b00);
      default:        return 1'b1;
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid_m) begin
          accept     = 1'b1;
          cnt_next   = CW'(LATENCY - 1);
          state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_valid_m) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg <= CW'(1)) begin
          state_next = ST_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      funct3_reg <= '0;
      write_reg  <= 1'b0;
      mis_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg   <= req_addr_m[AW+1:0];
        wdata_reg  <= req_wdata_m;
        funct3_reg <= req_funct3_m;
        write_reg  <= req_write_m;
        mis_reg    <= is_misaligned(req_funct3_m, req_addr_m[1:0]);
      end
    end
  end

  // With LATENCY=1 the read happens straight from IDLE, before the address is latched.
  assign rd_idx = (state_reg == ST_IDLE) ? req_addr_m[AW+1:2] : addr_reg[AW+1:2];
  assign rd_en  = (state_next == ST_RESP);
  assign wr_idx = addr_reg[AW+1:2];
  assign wr_en  = (state_reg == ST_RESP) && write_reg && !mis_reg;

  always_comb begin
    byte_en = '0;
    wr_data = wdata_reg;
    case (funct3_reg[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_reg[1:0];
        wr_data = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        byte_en = addr_reg[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_reg[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = '0;
    endcase
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] rd_byte;

    always_ff @(posedge clk) begin
      if (wr_en && byte_en[gi]) ram[wr_idx] <= wr_data[8*gi +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_byte <= '0;
      else if (rd_en) rd_byte <= ram[rd_idx];
    end

    assign rdata_q[8*gi +: 8] = rd_byte;
  end

  always_comb begin
    ld_byte  = rdata_q[{addr_reg[1:0], 3'b000} +: 8];
    ld_half  = addr_reg[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_ext = '0;
    case (funct3_reg)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_ext = {24'b0, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_ext = {16'b0, ld_half};
      3'b010:  load_ext = rdata_q;
      default: load_ext = '0;
    endcase
  end

  assign stall_m      = ((state_reg == ST_IDLE) && req_valid_m) || (state_reg == ST_WAIT);
  assign resp_valid_m = (state_reg == ST_RESP);
  assign misaligned_m = resp_valid_m && mis_reg;
  assign readdata_m   = (resp_valid_m && !write_reg && !mis_reg) ? load_ext : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for functional cases
// and a LATENCY=1 instance for the back-to-back stream.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, readdata;
  logic        stall, resp_valid, misaligned;

  logic        rst_b, req_valid_b, req_write_b;
  logic [2:0]  req_funct3_b;
  logic [31:0] req_addr_b, req_wdata_b, readdata_b;
  logic        stall_b, resp_valid_b, misaligned_b;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  dmem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid_m(req_valid), .req_write_m(req_write),
    .req_funct3_m(req_funct3), .req_addr_m(req_addr), .req_wdata_m(req_wdata),
    .stall_m(stall), .resp_valid_m(resp_valid), .readdata_m(readdata),
    .misaligned_m(misaligned)
  );

  dmem_responder #(.DATA_WIDTH(32), .DEPTH(1024), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid_m(req_valid_b), .req_write_m(req_write_b),
    .req_funct3_m(req_funct3_b), .req_addr_m(req_addr_b), .req_wdata_m(req_wdata_b),
    .stall_m(stall_b), .resp_valid_m(resp_valid_b), .readdata_m(readdata_b),
    .misaligned_m(misaligned_b)
  );

  // Runs one access on the LATENCY=2 instance starting just after a rising edge;
  // returns stall count, response cycle (-1 if none within the budget) and response data.
  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int stalls, output int resp_cyc,
                        output logic [31:0] rd, output logic mis);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    stalls = 0; resp_cyc = -1; rd = '0; mis = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (resp_valid) begin
        resp_cyc = c; rd = readdata; mis = misaligned;
      end
      @(posedge clk); #1;
      if (resp_cyc >= 0) break;
    end
    req_valid = 1'b0;
    $display("txn %s f3=%b addr=%h wdata=%h -> stalls=%0d resp_cyc=%0d rdata=%h mis=%b",
             w ? "st" : "ld", f3, a, d, stalls, resp_cyc, rd, mis);
  endtask

  task automatic test_reset;
    rst = 1'b0; rst_b = 1'b0;
    req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    req_valid_b = 0; req_write_b = 0; req_funct3_b = 0; req_addr_b = 0; req_wdata_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b expected 0", resp_valid); end
    n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", readdata); end
    n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b expected 0", misaligned); end
    @(posedge clk); #1;
    rst = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_word;
    int st, rc; logic [31:0] rd; logic mis;
    access(1'b1, F_W, 32'h10, 32'hDEADBEEF, st, rc, rd, mis);
    n_checks++; if (st !== 2) begin n_fail++; $display("FAIL sw_stalls: got %0d expected 2", st); end
    n_checks++; if (rc !== 2) begin n_fail++; $display("FAIL sw_resp_cycle: got %0d expected 2", rc); end
    n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL sw_mis: got %b expected 0", mis); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h expected 0", rd); end
    access(1'b0, F_W, 32'h10, 32'h0, st, rc, rd, mis);
    n_checks++; if (rc !== 2) begin n_fail++; $display("FAIL lw_resp_cycle: got %0d expected 2", rc); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
  endtask

  task automatic test_subword_load;
    int st, rc; logic [31:0] rd; logic mis;
    logic [2:0]  f3s  [4] = '{F_B, F_BU, F_H, F_HU};
    logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      access(1'b0, f3s[i], adrs[i], 32'h0, st, rc, rd, mis);
      n_checks++;
      if (rd !== exps[i] || mis !== 1'b0) begin
        n_fail++; $display("FAIL subword_load_%0d: got %h mis=%b expected %h mis=0", i, rd, mis, exps[i]);
      end
    end
  endtask

  task automatic test_subword_store;
    int st, rc; logic [31:0] rd; logic mis;
    access(1'b1, F_B, 32'h11, 32'h00000055, st, rc, rd, mis);
    access(1'b0, F_W, 32'h10, 32'h0, st, rc, rd, mis);
    n_checks++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb_merge: got %h expected dead55ef", rd); end
    access(1'b1, F_H, 32'h12, 32'h00001234, st, rc, rd, mis);
    access(1'b0, F_W, 32'h10, 32'h0, st, rc, rd, mis);
    n_checks++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL sh_merge: got %h expected 123455ef", rd); end
  endtask

  task automatic test_misaligned;
    int st, rc; logic [31:0] rd; logic mis;
    access(1'b0, F_W, 32'h12, 32'h0, st, rc, rd, mis);
    n_checks++; if (mis !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL lw_misaligned: got mis=%b rd=%h expected mis=1 rd=0", mis, rd); end
    access(1'b1, F_H, 32'h11, 32'h0000FFFF, st, rc, rd, mis);
    n_checks++; if (mis !== 1'b1) begin n_fail++; $display("FAIL sh_misaligned: got mis=%b expected 1", mis); end
    access(1'b0, 3'b011, 32'h10, 32'h0, st, rc, rd, mis);
    n_checks++; if (mis !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL bad_funct3: got mis=%b rd=%h expected mis=1 rd=0", mis, rd); end
    access(1'b0, F_W, 32'h10, 32'h0, st, rc, rd, mis);
    n_checks++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL mis_no_write: got %h expected 123455ef", rd); end
    access(1'b0, F_W, 32'h1010, 32'h0, st, rc, rd, mis);
    n_checks++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL addr_wrap: got %h expected 123455ef", rd); end
  endtask

  task automatic test_abort;
    int st, rc; logic [31:0] rd; logic mis;
    access(1'b1, F_W, 32'h20, 32'h11223344, st, rc, rd, mis);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F_W; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL abort_wait: got resp=%b stall=%b expected resp=0 stall=1", resp_valid, stall); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0 || stall !== 1'b0 || readdata !== 32'h0) begin
      n_fail++; $display("FAIL abort_idle: got resp=%b stall=%b rd=%h expected 0 0 0", resp_valid, stall, readdata);
    end
    @(posedge clk); #1;
    $display("txn st aborted addr=00000020 wdata=aaaa5555");
    access(1'b0, F_W, 32'h20, 32'h0, st, rc, rd, mis);
    n_checks++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL abort_no_write: got %h expected 11223344", rd); end
  endtask

  task automatic test_reset_midflight;
    int st, rc; logic [31:0] rd; logic mis;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F_W; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0 || resp_valid !== 1'b0 || readdata !== 32'h0 || misaligned !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: got stall=%b resp=%b rd=%h mis=%b expected all 0", stall, resp_valid, readdata, misaligned);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    $display("txn st reset-dropped addr=00000020 wdata=aaaa5555");
    access(1'b0, F_W, 32'h20, 32'h0, st, rc, rd, mis);
    n_checks++; if (rd !== 32'h11223344 || rc !== 2) begin
      n_fail++; $display("FAIL reset_no_write: got %h at cycle %0d expected 11223344 at cycle 2", rd, rc);
    end
  endtask

  task automatic test_back_to_back;
    logic        ws [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] as [4] = '{32'h40, 32'h44, 32'h40, 32'h40};
    logic [31:0] ds [4] = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
    for (int i = 0; i < 4; i++) begin
      req_valid_b = 1'b1; req_write_b = ws[i]; req_funct3_b = F_W; req_addr_b = as[i]; req_wdata_b = ds[i];
      @(negedge clk);
      n_checks++; if (stall_b !== 1'b1 || resp_valid_b !== 1'b0) begin
        n_fail++; $display("FAIL b2b_accept_%0d: got stall=%b resp=%b expected stall=1 resp=0", i, stall_b, resp_valid_b);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (stall_b !== 1'b0 || resp_valid_b !== 1'b1) begin
        n_fail++; $display("FAIL b2b_resp_%0d: got stall=%b resp=%b expected stall=0 resp=1", i, stall_b, resp_valid_b);
      end
      $display("txn b2b %s addr=%h wdata=%h -> rdata=%h", ws[i] ? "st" : "ld", as[i], ds[i], readdata_b);
      if (i == 3) begin
        n_checks++; if (readdata_b !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_final_load: got %h expected cafef00d", readdata_b); end
      end
      @(posedge clk); #1;
    end
    req_valid_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_load();
    test_subword_store();
    test_misaligned();
    test_abort();
    test_reset_midflight();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
